// File: rtl/wasm_i64_stack_issue.sv
// Issue stage between dispatch, the value-stack controller and the i64 ALU.
// Optional WASM_I64_ISSUE_PERF_EN adds perf_retired/perf_trapped event counters.
package wasm_i64_pkg;
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,  ALU_SUB    = 5'd1,  ALU_MUL    = 5'd2,  ALU_DIV_S  = 5'd3,
    ALU_DIV_U  = 5'd4,  ALU_REM_S  = 5'd5,  ALU_REM_U  = 5'd6,  ALU_AND    = 5'd7,
    ALU_OR     = 5'd8,  ALU_XOR    = 5'd9,  ALU_SHL    = 5'd10, ALU_SHR_S  = 5'd11,
    ALU_SHR_U  = 5'd12, ALU_ROTL   = 5'd13, ALU_ROTR   = 5'd14, ALU_CLZ    = 5'd15,
    ALU_CTZ    = 5'd16, ALU_POPCNT = 5'd17, ALU_EQZ    = 5'd18, ALU_EQ     = 5'd19,
    ALU_NE     = 5'd20, ALU_LT_S   = 5'd21, ALU_LT_U   = 5'd22
  } alu_op_t;

  typedef enum logic [2:0] {
    TRAP_NONE         = 3'd0,
    TRAP_INT_DIV_ZERO = 3'd1,
    TRAP_INT_OVERFLOW = 3'd2,
    TRAP_INVALID_CONV = 3'd3
  } trap_t;
endpackage

module wasm_i64_stack_issue
  import wasm_i64_pkg::*;
#(
  parameter int DEPTH_W     = 16,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  alu_op_t            cmd_op,
  input  logic               cmd_unary,
  input  logic [DEPTH_W-1:0] stack_depth,
  output logic               pop_req,
  input  logic               pop_ack,
  input  logic [63:0]        pop_data,
  output logic               push_req,
  input  logic               push_ack,
  output logic [63:0]        push_data,
  output logic               alu_valid,
  output alu_op_t            alu_op,
  output logic [63:0]        alu_a,
  output logic [63:0]        alu_b,
  input  logic               alu_valid_out,
  input  logic [63:0]        alu_result,
  input  trap_t              alu_trap,
  output logic               done,
  output logic               trap_valid,
  output trap_t              trap_code,
  output logic               err_underflow,
  output logic               err_timeout,
  input  logic               trap_ack
`ifdef WASM_I64_ISSUE_PERF_EN
  ,
  output logic [31:0]        perf_retired,
  output logic [31:0]        perf_trapped
`endif
);

  localparam int TMO_W = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, POP_B, POP_A, EXEC, PUSH, TRAPPED} state_t;

  state_t             state_r;
  logic [TMO_W-1:0]   tmo_cnt_r;
  logic [DEPTH_W-1:0] arity_s;

  assign arity_s = cmd_unary ? DEPTH_W'(1) : DEPTH_W'(2);

  // Issue FSM; every output is a register updated on the transition that changes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cmd_ready     <= 1'b1;
      pop_req       <= 1'b0;
      push_req      <= 1'b0;
      push_data     <= 64'd0;
      alu_valid     <= 1'b0;
      alu_op        <= ALU_ADD;
      alu_a         <= 64'd0;
      alu_b         <= 64'd0;
      done          <= 1'b0;
      trap_valid    <= 1'b0;
      trap_code     <= TRAP_NONE;
      err_underflow <= 1'b0;
      err_timeout   <= 1'b0;
      tmo_cnt_r     <= '0;
    end else begin
      done          <= 1'b0;
      err_underflow <= 1'b0;
      err_timeout   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_op <= cmd_op;
            alu_a  <= 64'd0;
            alu_b  <= 64'd0;
            if (stack_depth < arity_s) begin
              err_underflow <= 1'b1;
            end else begin
              cmd_ready <= 1'b0;
              pop_req   <= 1'b1;
              state_r   <= cmd_unary ? POP_A : POP_B;
            end
          end
        end
        // Top of stack is operand b for binary ops.
        POP_B: begin
          if (pop_ack) begin
            alu_b   <= pop_data;
            state_r <= POP_A;
          end
        end
        POP_A: begin
          if (pop_ack) begin
            alu_a     <= pop_data;
            pop_req   <= 1'b0;
            alu_valid <= 1'b1;
            tmo_cnt_r <= '0;
            state_r   <= EXEC;
          end
        end
        EXEC: begin
          if (alu_valid_out) begin
            alu_valid <= 1'b0;
            if (alu_trap == TRAP_NONE) begin
              push_data <= alu_result;
              push_req  <= 1'b1;
              state_r   <= PUSH;
            end else begin
              trap_code  <= alu_trap;
              trap_valid <= 1'b1;
              state_r    <= TRAPPED;
            end
          end else if (tmo_cnt_r == TMO_MAX) begin
            // Operands are already consumed; nothing is pushed back.
            alu_valid   <= 1'b0;
            err_timeout <= 1'b1;
            cmd_ready   <= 1'b1;
            state_r     <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        PUSH: begin
          if (push_ack) begin
            push_req  <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end
        end
        TRAPPED: begin
          if (trap_ack) begin
            trap_valid <= 1'b0;
            trap_code  <= TRAP_NONE;
            cmd_ready  <= 1'b1;
            state_r    <= IDLE;
          end
        end
        default: begin
          pop_req   <= 1'b0;
          push_req  <= 1'b0;
          alu_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

`ifdef WASM_I64_ISSUE_PERF_EN
  // Event counters: retirements follow the done pulse, traps count on entry to TRAPPED.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_retired <= 32'd0;
      perf_trapped <= 32'd0;
    end else begin
      if (done) begin
        perf_retired <= perf_retired + 32'd1;
      end
      if ((state_r == EXEC) && alu_valid_out && (alu_trap != TRAP_NONE)) begin
        perf_trapped <= perf_trapped + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wasm_i64_stack_issue.sv
// Directed self-checking bench for wasm_i64_stack_issue with a stack/ALU responder.
// Define WASM_I64_ISSUE_PERF_EN to also exercise the perf counters.
`timescale 1ns/1ps
module tb_wasm_i64_stack_issue;
  import wasm_i64_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  alu_op_t     cmd_op;
  logic        cmd_unary;
  logic [15:0] stack_depth;
  logic        pop_req, pop_ack;
  logic [63:0] pop_data;
  logic        push_req, push_ack;
  logic [63:0] push_data;
  logic        alu_valid;
  alu_op_t     alu_op;
  logic [63:0] alu_a, alu_b;
  logic        alu_valid_out;
  logic [63:0] alu_result;
  trap_t       alu_trap;
  logic        done, trap_valid;
  trap_t       trap_code;
  logic        err_underflow, err_timeout;
  logic        trap_ack;
`ifdef WASM_I64_ISSUE_PERF_EN
  logic [31:0] perf_retired, perf_trapped;
`endif

  int checks = 0;
  int errors = 0;

  // responder knobs (written by the test process only)
  int          pop_lat = 0;
  logic        push_en = 1'b1;
  logic        alu_en  = 1'b1;
  int          pop_base = 0;
  logic [63:0] pop_vals [4];

  // responder state (written by the responder process only)
  int          pops = 0, pushes = 0, pop_wait = 0;
  int          pop_req_cycles = 0, alu_cycles = 0;
  int          dones = 0, uf_cnt = 0, to_cnt = 0;
  logic [63:0] last_push = 64'd0;

  always #5 clk = ~clk;

  wasm_i64_stack_issue #(.DEPTH_W(16), .ALU_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_unary(cmd_unary),
    .stack_depth(stack_depth),
    .pop_req(pop_req), .pop_ack(pop_ack), .pop_data(pop_data),
    .push_req(push_req), .push_ack(push_ack), .push_data(push_data),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_valid_out(alu_valid_out), .alu_result(alu_result), .alu_trap(alu_trap),
    .done(done), .trap_valid(trap_valid), .trap_code(trap_code),
    .err_underflow(err_underflow), .err_timeout(err_timeout), .trap_ack(trap_ack)
`ifdef WASM_I64_ISSUE_PERF_EN
    , .perf_retired(perf_retired), .perf_trapped(perf_trapped)
`endif
  );

  function automatic logic [63:0] clz64(input logic [63:0] v);
    int   n = 0;
    logic seen = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) seen = 1'b1;
      if (!seen) n++;
    end
    return 64'(n);
  endfunction

  // Stack controller stand-in: acks after pop_lat waiting cycles, serves pop_vals in order.
  assign pop_ack  = pop_req && (pop_wait == pop_lat);
  assign pop_data = pop_vals[2'(pops - pop_base)];
  assign push_ack = push_req && push_en;

  // Combinational reference ALU.
  always_comb begin
    alu_valid_out = alu_valid && alu_en;
    alu_trap      = TRAP_NONE;
    alu_result    = 64'd0;
    case (alu_op)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_CLZ: alu_result = clz64(alu_a);
      ALU_DIV_U: begin
        if (alu_b == 64'd0) alu_trap = TRAP_INT_DIV_ZERO;
        else alu_result = alu_a / alu_b;
      end
      ALU_DIV_S: begin
        if (alu_b == 64'd0) alu_trap = TRAP_INT_DIV_ZERO;
        else alu_result = 64'($signed(alu_a) / $signed(alu_b));
      end
      default: alu_result = 64'd0;
    endcase
  end

  // Event bookkeeping sampled at each active edge.
  always @(posedge clk) begin
    if (pop_req && pop_ack) begin
      pops     <= pops + 1;
      pop_wait <= 0;
    end else if (pop_req) begin
      pop_wait <= pop_wait + 1;
    end else begin
      pop_wait <= 0;
    end
    if (push_req && push_ack) begin
      pushes    <= pushes + 1;
      last_push <= push_data;
    end
    if (pop_req)       pop_req_cycles <= pop_req_cycles + 1;
    if (alu_valid)     alu_cycles     <= alu_cycles + 1;
    if (done)          dones          <= dones + 1;
    if (err_underflow) uf_cnt         <= uf_cnt + 1;
    if (err_timeout)   to_cnt         <= to_cnt + 1;
  end

  task automatic load_ops(input logic [63:0] a, input logic [63:0] b);
    pop_base    = pops;
    pop_vals[0] = b;
    pop_vals[1] = a;
  endtask

  // Offers one command; lat counts cycles after the accept cycle until an outcome is visible.
  task automatic issue(input alu_op_t op, input logic un, input logic [15:0] d,
                       input int budget, output int lat);
    cmd_op = op; cmd_unary = un; stack_depth = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!(done || err_timeout || trap_valid || err_underflow) && lat < budget) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if ({pop_req, push_req, alu_valid, done, trap_valid, err_underflow, err_timeout} !== 7'd0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000000",
        {pop_req, push_req, alu_valid, done, trap_valid, err_underflow, err_timeout}); end
    checks++; if (trap_code !== TRAP_NONE) begin errors++; $display("FAIL reset_trap_code got=%0d exp=0", trap_code); end
    checks++; if ({alu_a, alu_b, push_data} !== 192'd0) begin errors++;
      $display("FAIL reset_data got a=%h b=%h p=%h exp=0", alu_a, alu_b, push_data); end
  endtask

  task automatic test_add();
    int lat, p0;
    p0 = pushes;
    load_ops(64'd5, 64'd7);
    issue(ALU_ADD, 1'b0, 16'd2, 40, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency got=%0d exp=5", lat); end
    checks++; if (alu_a !== 64'd5 || alu_b !== 64'd7) begin errors++;
      $display("FAIL add_operands got a=%0d b=%0d exp a=5 b=7", alu_a, alu_b); end
    checks++; if (last_push !== 64'd12 || pushes - p0 !== 1) begin errors++;
      $display("FAIL add_push got=%0d n=%0d exp=12 n=1", last_push, pushes - p0); end
  endtask

  task automatic test_sub_delayed();
    int lat, c0;
    c0 = pop_req_cycles;
    pop_lat = 3;
    load_ops(64'd3, 64'd10);
    issue(ALU_SUB, 1'b0, 16'd5, 60, lat);
    pop_lat = 0;
    checks++; if (lat !== 11) begin errors++; $display("FAIL sub_latency got=%0d exp=11", lat); end
    checks++; if (pop_req_cycles - c0 !== 8) begin errors++;
      $display("FAIL sub_pop_req_held got=%0d exp=8", pop_req_cycles - c0); end
    checks++; if (last_push !== 64'hFFFF_FFFF_FFFF_FFF9) begin errors++;
      $display("FAIL sub_push got=%h exp=fffffffffffffff9", last_push); end
  endtask

  task automatic test_trap();
    int lat, p0, q0;
    p0 = pushes;
    load_ops(64'd42, 64'd0);
    issue(ALU_DIV_S, 1'b0, 16'd2, 40, lat);
    checks++; if (trap_valid !== 1'b1 || trap_code !== TRAP_INT_DIV_ZERO) begin errors++;
      $display("FAIL trap_raise got v=%b code=%0d exp v=1 code=1", trap_valid, trap_code); end
    // Commands offered while trapped must not be consumed.
    q0 = pops;
    stack_depth = 16'd2; cmd_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (trap_valid !== 1'b1 || cmd_ready !== 1'b0 || pops !== q0) begin errors++;
      $display("FAIL trap_sticky got v=%b rdy=%b pops=%0d exp v=1 rdy=0 pops=%0d", trap_valid, cmd_ready, pops, q0); end
    cmd_valid = 1'b0;
    checks++; if (pushes !== p0) begin errors++; $display("FAIL trap_no_push got=%0d exp=%0d", pushes, p0); end
    @(negedge clk); trap_ack = 1'b1;
    @(posedge clk); #1; trap_ack = 1'b0;
    checks++; if (trap_valid !== 1'b0 || trap_code !== TRAP_NONE || cmd_ready !== 1'b1) begin errors++;
      $display("FAIL trap_ack got v=%b code=%0d rdy=%b exp v=0 code=0 rdy=1", trap_valid, trap_code, cmd_ready); end
  endtask

  task automatic test_unary();
    int lat, c0, u0;
    c0 = pop_req_cycles; u0 = uf_cnt;
    load_ops(64'd1, 64'd0);
    issue(ALU_CLZ, 1'b1, 16'd0, 10, lat);
    checks++; if (lat !== 1 || err_underflow !== 1'b1) begin errors++;
      $display("FAIL underflow_pulse got lat=%0d uf=%b exp lat=1 uf=1", lat, err_underflow); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pop_req_cycles !== c0 || uf_cnt - u0 !== 1 || cmd_ready !== 1'b1) begin errors++;
      $display("FAIL underflow_quiet got pops=%0d ufs=%0d rdy=%b exp pops=0 ufs=1 rdy=1",
        pop_req_cycles - c0, uf_cnt - u0, cmd_ready); end
    pop_base = pops; pop_vals[0] = 64'd1;
    issue(ALU_CLZ, 1'b1, 16'd1, 40, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL clz_latency got=%0d exp=4", lat); end
    checks++; if (last_push !== 64'd63 || alu_b !== 64'd0) begin errors++;
      $display("FAIL clz_push got=%0d b=%0d exp=63 b=0", last_push, alu_b); end
  endtask

  task automatic test_timeout();
    int lat, p0, a0, t0;
    p0 = pushes; a0 = alu_cycles; t0 = to_cnt;
    alu_en = 1'b0;
    load_ops(64'd1, 64'd2);
    issue(ALU_ADD, 1'b0, 16'd2, 100, lat);
    checks++; if (lat !== 67 || err_timeout !== 1'b1) begin errors++;
      $display("FAIL timeout_latency got lat=%0d to=%b exp lat=67 to=1", lat, err_timeout); end
    @(posedge clk); #1;
    alu_en = 1'b1;
    checks++; if (alu_cycles - a0 !== 64 || to_cnt - t0 !== 1 || pushes !== p0 || cmd_ready !== 1'b1) begin errors++;
      $display("FAIL timeout_effects got alu=%0d to=%0d push=%0d rdy=%b exp alu=64 to=1 push=0 rdy=1",
        alu_cycles - a0, to_cnt - t0, pushes - p0, cmd_ready); end
  endtask

  task automatic test_reset_in_push();
    int n, p0;
    p0 = pushes;
    push_en = 1'b0;
    load_ops(64'd4, 64'd4);
    cmd_op = ALU_ADD; cmd_unary = 1'b0; stack_depth = 16'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!push_req && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (push_req !== 1'b1) begin errors++; $display("FAIL push_wait got=%b exp=1", push_req); end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (push_req !== 1'b0 || cmd_ready !== 1'b1 || push_data !== 64'd0) begin errors++;
      $display("FAIL reset_in_push got req=%b rdy=%b data=%0d exp req=0 rdy=1 data=0", push_req, cmd_ready, push_data); end
    @(negedge clk); rst_n = 1'b1; push_en = 1'b1;
    checks++; if (pushes !== p0) begin errors++; $display("FAIL reset_no_push got=%0d exp=0", pushes - p0); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, d0;
    d0 = dones;
    pop_base = pops;
    pop_vals[0] = 64'd2;   pop_vals[1] = 64'd1;
    pop_vals[2] = 64'd200; pop_vals[3] = 64'd100;
    issue(ALU_ADD, 1'b0, 16'd4, 40, lat1);
    checks++; if (last_push !== 64'd3) begin errors++; $display("FAIL b2b_first got=%0d exp=3", last_push); end
    issue(ALU_ADD, 1'b0, 16'd2, 40, lat2);
    checks++; if (lat1 !== 5 || lat2 !== 5) begin errors++;
      $display("FAIL b2b_latency got=%0d,%0d exp=5,5", lat1, lat2); end
    checks++; if (last_push !== 64'd300) begin errors++; $display("FAIL b2b_second got=%0d exp=300", last_push); end
    @(posedge clk); #1;
    checks++; if (dones - d0 !== 2) begin errors++; $display("FAIL b2b_dones got=%0d exp=2", dones - d0); end
  endtask

`ifdef WASM_I64_ISSUE_PERF_EN
  task automatic test_perf();
    int lat;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load_ops(64'(i), 64'd1);
      issue(ALU_ADD, 1'b0, 16'd2, 40, lat);
    end
    load_ops(64'd9, 64'd0);
    issue(ALU_DIV_U, 1'b0, 16'd2, 40, lat);
    @(negedge clk); trap_ack = 1'b1;
    @(posedge clk); #1; trap_ack = 1'b0;
    checks++; if (perf_retired !== 32'd3 || perf_trapped !== 32'd1) begin errors++;
      $display("FAIL perf_counts got ret=%0d trp=%0d exp ret=3 trp=1", perf_retired, perf_trapped); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = ALU_ADD; cmd_unary = 1'b0;
    stack_depth = 16'd0; trap_ack = 1'b0;
    for (int i = 0; i < 4; i++) pop_vals[i] = 64'd0;
    test_reset();
    test_add();
    test_sub_delayed();
    test_trap();
    test_unary();
    test_timeout();
    test_reset_in_push();
    test_back_to_back();
`ifdef WASM_I64_ISSUE_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
